// File: rtl/cr16_uart_loader_if.sv
// BRAM port-A write bus between the UART program loader (master) and the CR16 program memory (slave).
interface cr16_uart_loader_if #(
  parameter int P_ADDRESS_WIDTH = 10,
  parameter int P_DATA_WIDTH    = 16
);
  logic [P_DATA_WIDTH-1:0]    mem_data;
  logic [P_ADDRESS_WIDTH-1:0] mem_address;
  logic                       mem_write_enable;

  modport master (output mem_data, output mem_address, output mem_write_enable);
  modport slave  (input  mem_data, input  mem_address, input  mem_write_enable);
endinterface

// File: rtl/cr16_uart_loader.sv
// Receives a length-prefixed, XOR-checksummed image over 8N1 UART and writes it word by word
// into CR16 program BRAM from address 0; O_LOAD_DONE releases the processor.
module cr16_uart_loader #(
  parameter int P_CLK_HZ        = 50000000,
  parameter int P_BAUD          = 115200,
  parameter int P_ADDRESS_WIDTH = 10,
  parameter int P_DATA_WIDTH    = 16
) (
  input  logic                     I_CLK,
  input  logic                     I_NRESET,
  input  logic                     I_RX,
  input  logic                     I_START,
  cr16_uart_loader_if.master       bram,
  output logic                     O_BUSY,
  output logic                     O_LOAD_DONE,
  output logic                     O_ERROR,
  output logic [1:0]               O_ERROR_CODE,
  output logic [P_ADDRESS_WIDTH:0] O_WORD_COUNT
);
  localparam int BIT_CYCLES  = P_CLK_HZ / P_BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(2 ** P_ADDRESS_WIDTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
  } state_t;

  rx_state_t        rx_state, rx_state_nxt;
  logic             rx_s1, rx_s2, rx_d;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             byte_valid, frame_err;

  state_t                   state, state_nxt;
  logic [1:0]               code_nxt;
  logic                     start_ok;
  logic [7:0]               len_hi, data_hi, csum;
  logic [P_ADDRESS_WIDTH:0] n_words;
  logic [16:0]              len_word;

  // UART receiver: start-bit qualification at mid-bit, then one sample per bit period
  always_comb begin
    rx_state_nxt = rx_state;
    byte_valid   = 1'b0;
    frame_err    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_d && !rx_s2) rx_state_nxt = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_nxt = RX_IDLE;
          byte_valid   = rx_s2;
          frame_err    = !rx_s2;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= I_RX;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      rx_state <= rx_state_nxt;
      if (rx_state == RX_IDLE || rx_state_nxt != rx_state || rx_cnt == BIT_LAST) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_DATA && rx_cnt == BIT_LAST) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  // Frame parser and BRAM writer
  assign len_word = {1'b0, len_hi, rx_shift};

  always_comb begin
    state_nxt = state;
    code_nxt  = O_ERROR_CODE;
    start_ok  = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (I_START) begin
          state_nxt = LEN_HI;
          code_nxt  = 2'b00;
          start_ok  = 1'b1;
        end
      end
      LEN_HI: if (byte_valid) state_nxt = LEN_LO;
      LEN_LO: begin
        if (byte_valid) begin
          if (len_word == 17'd0) state_nxt = CHECK;
          else if (len_word > MAX_WORDS) begin
            state_nxt = ERROR;
            code_nxt  = 2'b10;
          end else state_nxt = DATA_HI;
        end
      end
      DATA_HI: if (byte_valid) state_nxt = DATA_LO;
      DATA_LO: if (byte_valid) state_nxt = WRITE;
      WRITE:   state_nxt = (O_WORD_COUNT + 1'b1 == n_words) ? CHECK : DATA_HI;
      CHECK: begin
        if (byte_valid) begin
          if (rx_shift == csum) state_nxt = DONE;
          else begin
            state_nxt = ERROR;
            code_nxt  = 2'b11;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A broken frame aborts the load no matter what the parser was doing
    if (O_BUSY && frame_err) begin
      state_nxt = ERROR;
      code_nxt  = 2'b01;
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state            <= IDLE;
      O_ERROR_CODE     <= '0;
      O_WORD_COUNT     <= '0;
      len_hi           <= '0;
      data_hi          <= '0;
      csum             <= '0;
      n_words          <= '0;
      bram.mem_data    <= '0;
      bram.mem_address <= '0;
    end else begin
      state        <= state_nxt;
      O_ERROR_CODE <= code_nxt;
      if (start_ok) begin
        O_WORD_COUNT <= '0;
        csum         <= '0;
      end
      if (state == WRITE) O_WORD_COUNT <= O_WORD_COUNT + 1'b1;
      if (byte_valid) begin
        case (state)
          LEN_HI: len_hi <= rx_shift;
          LEN_LO: n_words <= len_word[P_ADDRESS_WIDTH:0];
          DATA_HI: begin
            data_hi <= rx_shift;
            csum    <= csum ^ rx_shift;
          end
          DATA_LO: begin
            csum             <= csum ^ rx_shift;
            bram.mem_data    <= {data_hi, rx_shift};
            bram.mem_address <= O_WORD_COUNT[P_ADDRESS_WIDTH-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign O_BUSY                = !(state inside {IDLE, DONE, ERROR});
  assign O_LOAD_DONE           = (state == DONE);
  assign O_ERROR               = (state == ERROR);
  assign bram.mem_write_enable = (state == WRITE);
endmodule

// File: doc/cr16_uart_loader.md
Name: cr16_uart_loader

Overview:
- Program loader upstream of the CR16 processor/BRAM pair.
- Receives a framed machine-code image over a UART serial line, assembles 16-bit words and writes them sequentially into BRAM port A from address 0.
- Asserts O_LOAD_DONE when the image is complete and its checksum matches; top level holds the processor in reset until then.

Parameters:
P_CLK_HZ, 50000000, I_CLK frequency in Hz
P_BAUD, 115200, UART bit rate; bit period P_BIT_CYCLES = P_CLK_HZ / P_BAUD (integer division; 434 at defaults)
P_ADDRESS_WIDTH, 10, BRAM address width; max image = 2**P_ADDRESS_WIDTH words
P_DATA_WIDTH, 16, BRAM word width (fixed two bytes per word)

Ports:
I_CLK  in  1  clock
I_NRESET  in  1  asynchronous active-low reset
I_RX  in  1  UART serial input, idle high, 8N1
I_START  in  1  single-cycle pulse: clear status, begin waiting for header
O_MEM_DATA  out  16  BRAM write data
O_MEM_ADDRESS  out  P_ADDRESS_WIDTH  BRAM write address
O_MEM_WRITE_ENABLE  out  1  one-cycle BRAM write strobe
O_BUSY  out  1  load in progress (any state other than IDLE/DONE/ERROR)
O_LOAD_DONE  out  1  image written and checksum OK (sticky)
O_ERROR  out  1  load aborted (sticky)
O_ERROR_CODE  out  2  01 frame error, 10 length error, 11 checksum error, 00 none
O_WORD_COUNT  out  P_ADDRESS_WIDTH+1  words written in current load

Behaviour:
- Reset: I_NRESET (asynchronous, active-low) clears all state; every output resets to 0; FSM enters IDLE; UART receiver enters RX_IDLE. Reset mid-load abandons the load; BRAM contents already written are not cleared.
- RX path: I_RX passes a 2-FF synchronizer (reset value 1). RX_IDLE detects a synchronized falling edge, then waits P_BIT_CYCLES/2. If the line is high at that point, it is a glitch and the receiver returns to RX_IDLE. Otherwise 8 data bits are sampled LSB first, each P_BIT_CYCLES apart, then the stop bit.
- Stop bit = 1: one-cycle internal byte_valid is raised with the byte.
- Stop bit = 0: frame error. The byte is discarded and the FSM goes to ERROR with code 01.
- Byte format: LEN_HI, LEN_LO (N words, big-endian); then N words, high byte first; then 1 checksum byte = XOR of all 2N data bytes (header excluded).
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR, I_START=1: clear O_LOAD_DONE, O_ERROR, O_ERROR_CODE, O_WORD_COUNT, the address counter and the checksum accumulator; go to LEN_HI. I_START while O_BUSY=1 is ignored. Bytes arriving in IDLE/DONE/ERROR are discarded.
- LEN_LO: N = 0 goes to CHECK. N > 2**P_ADDRESS_WIDTH goes to ERROR with code 10. Otherwise go to DATA_HI.
- DATA_LO byte accepted → WRITE for exactly one cycle. In WRITE: O_MEM_WRITE_ENABLE=1, O_MEM_DATA={hi,lo}, O_MEM_ADDRESS=current index. On the next cycle the index increments and O_WORD_COUNT increments. If O_WORD_COUNT reaches N, go to CHECK; else go to DATA_HI.
- Write latency: the strobe is asserted on the cycle after the low byte's byte_valid.
- Address wrap: cannot occur, because the length check bounds the index to 2**P_ADDRESS_WIDTH-1.
- O_MEM_DATA and O_MEM_ADDRESS hold their last values when O_MEM_WRITE_ENABLE=0.
- CHECK: when the received byte equals the accumulator, go to DONE (O_LOAD_DONE=1). Otherwise go to ERROR with code 11.
- O_LOAD_DONE and O_ERROR are mutually exclusive, and both are 0 while O_BUSY=1.
- A frame error in any busy state goes to ERROR with code 01, overriding other processing.

Test Plan:
- Reset: assert I_NRESET=0 mid-stream → all outputs 0, FSM IDLE. Release, then I_START → O_BUSY=1 and O_WORD_COUNT=0.
- Nominal (defaults): I_START, send 00 02 12 34 AB CD 40 at 434 cycles/bit → exactly two write strobes: addr 0 data 0x1234, then addr 1 data 0xABCD. Then O_LOAD_DONE=1, O_WORD_COUNT=2, O_BUSY=0.
- Checksum error: same stream with final byte 41 → both writes still occur. Then O_ERROR=1, O_ERROR_CODE=11, O_LOAD_DONE=0.
- Length error: send 04 01 → no write strobe, O_ERROR_CODE=10. Boundary: send 04 00 → accepted, O_BUSY stays 1 awaiting data.
- Zero length and framing: send 00 00 00 → O_LOAD_DONE=1 with no writes. Then I_START and send a byte with stop bit 0 → O_ERROR_CODE=01.
- Glitch and ignore cases: a 100-cycle low pulse on I_RX → no byte received. I_START pulsed mid-load → ignored, load completes normally. I_START after ERROR → flags clear and the load restarts.
